// File: rtl/elevator_pkg.sv
// Shared types and helpers for the 3-floor elevator shaft plant model.
// Floor points are derived from the inter-floor travel distance.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_UP    = 2'd1,
        ST_DOWN  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    // Floor k (1..3) sits at (k-1)*travel position units above floor 1.
    function automatic int floor_pos(input int k, input int travel);
        return (k - 1) * travel;
    endfunction

    function automatic int floor1_pos(input int travel);
        return floor_pos(1, travel);
    endfunction

    function automatic int floor2_pos(input int travel);
        return floor_pos(2, travel);
    endfunction

    function automatic int floor3_pos(input int travel);
        return floor_pos(3, travel);
    endfunction

    // Signed arithmetic so the band below floor 1 never wraps.
    function automatic logic in_band(input int p, input int point, input int band);
        return (p >= point - band) && (p <= point + band);
    endfunction

endpackage

// File: rtl/elevator_shaft_model_if.sv
// Controller <-> shaft signal bundle: motor commands one way, sensors/status the other.
// master = controller side, slave = shaft plant side.
interface elevator_shaft_model_if #(
    parameter int POS_W = 5
);
    logic             mup;
    logic             mdw;
    logic             f1;
    logic             f2;
    logic             f3;
    logic [POS_W-1:0] pos;
    logic             moving;
    logic             fault;

    modport master (
        output mup, mdw,
        input  f1, f2, f3, pos, moving, fault
    );

    modport slave (
        input  mup, mdw,
        output f1, f2, f3, pos, moving, fault
    );
endinterface

// File: rtl/elevator_step_timer.sv
// STEP_DIV prescaler: while run is high it emits one step pulse every STEP_DIV clocks.
// clear (or run low) restarts the count so the first step lands STEP_DIV clocks after start.
module elevator_step_timer #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic step
);
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt;

    assign step = run && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/elevator_shaft_model.sv
// Plant model of a 3-floor elevator shaft: integrates cabin position from mup/mdw and drives f1..f3.
// Define FAULT_LATCH_EN to latch conflict/overtravel into a FAULT state that only reset leaves.
module elevator_shaft_model
    import elevator_pkg::*;
#(
    parameter int TRAVEL      = 10,
    parameter int STEP_DIV    = 4,
    parameter int SENSOR_BAND = 1,
    parameter int POS_W       = 5
) (
    input logic                   clk,
    input logic                   reset,
    elevator_shaft_model_if.slave bus
);
    localparam logic [POS_W-1:0] TOP_POS = POS_W'(floor3_pos(TRAVEL));
    localparam int F1_POS = floor1_pos(TRAVEL);
    localparam int F2_POS = floor2_pos(TRAVEL);
    localparam int F3_POS = floor3_pos(TRAVEL);

    state_e           state;
    state_e           state_nxt;
    logic [POS_W-1:0] pos_q;
    logic [2:0]       sense_q;
    logic             run;
    logic             clear;
    logic             step;
    logic             pos_inc;
    logic             pos_dec;
    logic             conflict;
    logic             over_ev;
    logic             fault_ev;

    assign run   = (state == ST_UP) || (state == ST_DOWN);
    assign clear = (state_nxt != state);

    elevator_step_timer #(
        .STEP_DIV(STEP_DIV)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .clear(clear),
        .step (step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        pos_inc   = 1'b0;
        pos_dec   = 1'b0;
        over_ev   = 1'b0;
        conflict  = bus.mup && bus.mdw && (state != ST_FAULT);
        case (state)
            ST_STOP: begin
                if (!conflict && bus.mup) begin
                    if (pos_q == TOP_POS) over_ev = 1'b1;
                    else                  state_nxt = ST_UP;
                end else if (!conflict && bus.mdw) begin
                    if (pos_q == '0) over_ev = 1'b1;
                    else             state_nxt = ST_DOWN;
                end
            end
            // Movement needs the command still present, so a dropped command never sneaks in a step.
            ST_UP: begin
                if (conflict || !bus.mup) begin
                    state_nxt = ST_STOP;
                end else if (step) begin
                    if (pos_q == TOP_POS) over_ev = 1'b1;
                    else                  pos_inc = 1'b1;
                end
            end
            ST_DOWN: begin
                if (conflict || !bus.mdw) begin
                    state_nxt = ST_STOP;
                end else if (step) begin
                    if (pos_q == '0) over_ev = 1'b1;
                    else             pos_dec = 1'b1;
                end
            end
            default: state_nxt = state;
        endcase
        fault_ev = conflict || over_ev;
`ifdef FAULT_LATCH_EN
        if (fault_ev) begin
            state_nxt = ST_FAULT;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q <= '0;
        end else if (pos_inc) begin
            pos_q <= pos_q + 1'b1;
        end else if (pos_dec) begin
            pos_q <= pos_q - 1'b1;
        end
    end

    // Sensors trail pos by one clock, as a real limit switch sampled by the controller would.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sense_q <= 3'b001;
        end else begin
            sense_q[0] <= in_band(int'(pos_q), F1_POS, SENSOR_BAND);
            sense_q[1] <= in_band(int'(pos_q), F2_POS, SENSOR_BAND);
            sense_q[2] <= in_band(int'(pos_q), F3_POS, SENSOR_BAND);
        end
    end

`ifdef FAULT_LATCH_EN
    assign bus.fault = (state == ST_FAULT);
`else
    logic fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_ev;
        end
    end

    assign bus.fault = fault_q;
`endif

    assign bus.pos    = pos_q;
    assign bus.f1     = sense_q[0];
    assign bus.f2     = sense_q[1];
    assign bus.f3     = sense_q[2];
    assign bus.moving = run;
endmodule
